// File: rtl/pdm_capture_pkg.sv
// Shared state encoding and sample-width helper for pdm_capture_ctrl.
// PDM_SIGNED_OUT_EN widens the sample by one bit for two's-complement output.
package pdm_capture_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE    = 2'd0;
    localparam logic [STATE_W-1:0] ST_WARMUP  = 2'd1;
    localparam logic [STATE_W-1:0] ST_CAPTURE = 2'd2;

`ifdef PDM_SIGNED_OUT_EN
    localparam bit SIGNED_OUT = 1'b1;
`else
    localparam bit SIGNED_OUT = 1'b0;
`endif

    // A signed sample needs one extra bit to hold -WINDOW..+WINDOW.
    function automatic int sample_width(input int cnt_w);
        return SIGNED_OUT ? cnt_w + 1 : cnt_w;
    endfunction

endpackage

// File: rtl/pdm_clk_div.sv
// Mic clock divider: free-runs while run is high, parked at zero otherwise.
// mic_clk is registered from the next count so it lines up with div_cnt.
module pdm_clk_div #(
    parameter int CLK_DIV = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic mic_clk,
    output logic tick
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    logic [DIV_W-1:0] r_div_cnt;
    logic             r_running;
    logic             r_mic_clk;
    logic [DIV_W-1:0] w_div_nxt;

    // run is the next-cycle busy, so the first busy cycle starts at zero.
    always_comb begin
        w_div_nxt = '0;
        if (run && r_running) begin
            w_div_nxt = (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_running <= 1'b0;
            r_mic_clk <= 1'b0;
        end else begin
            r_div_cnt <= w_div_nxt;
            r_running <= run;
            r_mic_clk <= run && (w_div_nxt < DIV_HALF);
        end
    end

    assign tick    = r_running && (r_div_cnt == DIV_LAST);
    assign mic_clk = r_mic_clk;

endmodule

// File: rtl/pdm_capture_ctrl.sv
// PDM microphone sequencer: gated mic clock, warm-up hold-off, windowed ones count.
// Define PDM_SIGNED_OUT_EN for two's-complement samples (2*ones - WINDOW).
module pdm_capture_ctrl
    import pdm_capture_pkg::*;
#(
    parameter  int CLK_DIV     = 32,
    parameter  int WARMUP_CLKS = 8192,
    parameter  int WINDOW      = 64,
    parameter  int CNT_W       = $clog2(WINDOW + 1),
    localparam int SAMPLE_W    = sample_width(CNT_W)
) (
    input  logic                clk_8_192_MHz,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                pdm_data,
    output logic                mic_clk,
    output logic                busy,
    output logic [STATE_W-1:0]  state,
    output logic [SAMPLE_W-1:0] sample,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                overrun
);

    localparam int WARM_W = $clog2(WARMUP_CLKS + 1);
    localparam int BIT_W  = $clog2(WINDOW);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CLKS - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WINDOW - 1);

    logic [STATE_W-1:0]  r_state;
    logic [STATE_W-1:0]  w_state_nxt;
    logic [WARM_W-1:0]   r_warm_cnt;
    logic [BIT_W-1:0]    r_bit_cnt;
    logic [CNT_W-1:0]    r_acc;
    logic [SAMPLE_W-1:0] r_sample;
    logic                r_valid;
    logic                r_overrun;

    logic                w_tick;
    logic                w_run;
    logic                w_busy;
    logic                w_start_ok;
    logic                w_warm_done;
    logic                w_win_done;
    logic                w_xfer;
    logic [CNT_W-1:0]    w_ones;

    function automatic logic [SAMPLE_W-1:0] to_sample(input logic [CNT_W-1:0] ones);
`ifdef PDM_SIGNED_OUT_EN
        logic signed [SAMPLE_W-1:0] scaled;
        scaled = $signed({ones, 1'b0}) - $signed(SAMPLE_W'(WINDOW));
        return scaled;
`else
        return ones;
`endif
    endfunction

    assign w_busy      = (r_state != ST_IDLE);
    assign w_start_ok  = start && !stop;
    assign w_warm_done = (r_state == ST_WARMUP) && w_tick && (r_warm_cnt == WARM_LAST);
    // A stop on the final tick discards the window like any other stop.
    assign w_win_done  = (r_state == ST_CAPTURE) && !stop && w_tick && (r_bit_cnt == BIT_LAST);
    assign w_ones      = r_acc + CNT_W'(pdm_data);
    assign w_xfer      = r_valid && sample_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) w_state_nxt = ST_WARMUP;
            end
            ST_WARMUP: begin
                if (stop)             w_state_nxt = ST_IDLE;
                else if (w_warm_done) w_state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (stop) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_run = (w_state_nxt != ST_IDLE);

    pdm_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk     (clk_8_192_MHz),
        .reset   (reset),
        .run     (w_run),
        .mic_clk (mic_clk),
        .tick    (w_tick)
    );

    always_ff @(posedge clk_8_192_MHz) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_warm_cnt <= '0;
            r_bit_cnt  <= '0;
            r_acc      <= '0;
        end else begin
            r_state <= w_state_nxt;

            if ((r_state != ST_WARMUP) || stop || w_warm_done) begin
                r_warm_cnt <= '0;
            end else if (w_tick) begin
                r_warm_cnt <= r_warm_cnt + 1'b1;
            end

            if ((r_state != ST_CAPTURE) || stop || w_win_done) begin
                r_bit_cnt <= '0;
                r_acc     <= '0;
            end else if (w_tick) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
                r_acc     <= w_ones;
            end
        end
    end

    // Output slot: a pending sample is never overwritten, only flagged.
    always_ff @(posedge clk_8_192_MHz) begin
        if (reset) begin
            r_sample  <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_win_done) begin
                if (!r_valid || w_xfer) begin
                    r_sample <= to_sample(w_ones);
                    r_valid  <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end

            if ((r_state == ST_IDLE) && w_start_ok) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign busy         = w_busy;
    assign state        = r_state;
    assign sample       = r_sample;
    assign sample_valid = r_valid;
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// Directed bench for pdm_capture_ctrl with CLK_DIV=4, WARMUP_CLKS=3, WINDOW=8.
// Builds with or without PDM_SIGNED_OUT_EN; expected samples follow the build.
module tb_pdm_capture_ctrl;

`ifdef PDM_SIGNED_OUT_EN
    localparam int SW = 5;
`else
    localparam int SW = 4;
`endif

    logic          clk_8_192_MHz = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          pdm_data = 1'b0;
    logic          sample_ready = 1'b1;
    logic          mic_clk;
    logic          busy;
    logic [1:0]    state;
    logic [SW-1:0] sample;
    logic          sample_valid;
    logic          overrun;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] pat;
        int         ones;
    } vec_t;

    vec_t vecs [8];

    pdm_capture_ctrl #(
        .CLK_DIV     (4),
        .WARMUP_CLKS (3),
        .WINDOW      (8)
    ) dut (
        .clk_8_192_MHz (clk_8_192_MHz),
        .reset         (reset),
        .start         (start),
        .stop          (stop),
        .pdm_data      (pdm_data),
        .mic_clk       (mic_clk),
        .busy          (busy),
        .state         (state),
        .sample        (sample),
        .sample_valid  (sample_valid),
        .sample_ready  (sample_ready),
        .overrun       (overrun)
    );

    always #5 clk_8_192_MHz = ~clk_8_192_MHz;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    function automatic logic [SW-1:0] exp_sample(input int ones);
`ifdef PDM_SIGNED_OUT_EN
        return SW'(2 * ones - 8);
`else
        return SW'(ones);
`endif
    endfunction

    task automatic step();
        @(posedge clk_8_192_MHz);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Runs one 32-cycle window from a div_cnt==0 boundary; ends on the next boundary.
    task automatic run_window(input logic [7:0] pat, input int start_at,
                              input logic rdy, input int exp_v1);
        for (int c = 0; c < 32; c++) begin
            pdm_data = pat[c / 4];
            start = (c == start_at);
            if (c == 1) sample_ready = rdy;
            step();
            if (c == 0 && exp_v1 >= 0) chk("valid_after_first_cycle", int'(sample_valid), exp_v1);
        end
        start = 1'b0;
    endtask

    task automatic warmup_from_start(input bit check_clk);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("warmup_entry_state", int'(state), 1);
        chk("warmup_entry_busy", int'(busy), 1);
        chk("warmup_entry_mic_clk", int'(mic_clk), 1);
        chk("warmup_entry_overrun", int'(overrun), 0);
        for (int i = 1; i < 12; i++) begin
            step();
            chk("warmup_state", int'(state), 1);
            if (check_clk) chk("warmup_mic_clk", int'(mic_clk), ((i % 4) < 2) ? 1 : 0);
        end
        step();
        chk("capture_entry_state", int'(state), 2);
    endtask

    initial begin
        bit saw;

        vecs[0] = '{8'hFF, 8};
        vecs[1] = '{8'h55, 4};
        vecs[2] = '{8'h00, 0};
        vecs[3] = '{8'h01, 1};
        vecs[4] = '{8'h80, 1};
        vecs[5] = '{8'hF0, 4};
        vecs[6] = '{8'h7F, 7};
        vecs[7] = '{8'h3C, 4};

        // Reset and idle
        repeat (5) step();
        reset = 1'b0;
        step();
        chk("reset_mic_clk", int'(mic_clk), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_state", int'(state), 0);
        chk("reset_valid", int'(sample_valid), 0);
        chk("reset_overrun", int'(overrun), 0);
        chk("reset_sample", int'(sample), 0);

        // Start, warm-up, then back-to-back windows with ready high
        sample_ready = 1'b1;
        warmup_from_start(1'b1);
        for (int v = 0; v < 8; v++) begin
            run_window(vecs[v].pat, -1, 1'b1, 0);
            chk("table_valid", int'(sample_valid), 1);
            chk("table_sample", int'(sample), int'(exp_sample(vecs[v].ones)));
        end

        // Backpressure across two windows
        run_window(8'hFF, -1, 1'b0, 0);
        chk("bp_first_valid", int'(sample_valid), 1);
        chk("bp_first_sample", int'(sample), int'(exp_sample(8)));
        chk("bp_first_overrun", int'(overrun), 0);
        run_window(8'h00, -1, 1'b0, 1);
        chk("bp_held_valid", int'(sample_valid), 1);
        chk("bp_held_sample", int'(sample), int'(exp_sample(8)));
        chk("bp_overrun", int'(overrun), 1);
        sample_ready = 1'b1;
        pdm_data = 1'b1;
        step();
        chk("bp_drain_valid", int'(sample_valid), 0);
        chk("bp_drain_sample", int'(sample), int'(exp_sample(8)));
        chk("bp_drain_overrun", int'(overrun), 1);

        // Stop five ticks into a window
        repeat (19) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_state", int'(state), 0);
        chk("stop_mic_clk", int'(mic_clk), 0);
        chk("stop_busy", int'(busy), 0);
        saw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (sample_valid || mic_clk || state != 2'd0) saw = 1'b1;
        end
        chk("stop_quiet", int'(saw), 0);
        chk("stop_overrun_sticky", int'(overrun), 1);

        // start together with stop stays idle
        start = 1'b1;
        stop = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b0;
        chk("start_stop_state", int'(state), 0);
        chk("start_stop_busy", int'(busy), 0);

        // Restart repeats the whole warm-up; start during capture is ignored
        warmup_from_start(1'b0);
        run_window(8'h55, 5, 1'b1, 0);
        chk("restart_state", int'(state), 2);
        chk("restart_valid", int'(sample_valid), 1);
        chk("restart_sample", int'(sample), int'(exp_sample(4)));

        // Reset mid-capture with a pending sample and overrun set
        run_window(8'hFF, -1, 1'b0, 0);
        run_window(8'h00, -1, 1'b0, 1);
        chk("pre_reset_overrun", int'(overrun), 1);
        repeat (10) step();
        reset = 1'b1;
        step();
        chk("midrst_mic_clk", int'(mic_clk), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_state", int'(state), 0);
        chk("midrst_valid", int'(sample_valid), 0);
        chk("midrst_overrun", int'(overrun), 0);
        chk("midrst_sample", int'(sample), 0);
        reset = 1'b0;
        sample_ready = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (mic_clk || busy || state != 2'd0) saw = 1'b1;
        end
        chk("post_reset_idle", int'(saw), 0);
        warmup_from_start(1'b0);
        run_window(8'h07, -1, 1'b1, 0);
        chk("resume_valid", int'(sample_valid), 1);
        chk("resume_sample", int'(sample), int'(exp_sample(3)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
